// File: rtl/pipeline_top.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_top (with pipeline_pc_reg, pipeline_imem,
//               pipeline_fetch)
// Description : Five-stage IF/ID/RR/EX/WB pipeline for a small x86-like
//               integer subset (NOP, MOV r,imm, ADD/SUB EAX,imm, INC/DEC r,
//               MOV/ADD rm,reg with mod=11, HLT). Eight 32-bit registers.
//               Build option: PIPELINE_FORWARD_EN
//                 defined   -> EX/WB results forwarded into RR, no RAW stalls
//                 undefined -> RR stalls while EX or WB still owes a register
//                              that RR reads
// Ports       : clk          - single clock, rising edge
//               rst          - asynchronous reset, active low
//               debug_pc     - current fetch PC
//               debug_result - WB-stage result
// Revision    : 1.0 - initial release
// ============================================================================

// ---------------------------------------------------------------------------
// Program counter register. Cleared by reset, loaded when enabled.
// ---------------------------------------------------------------------------
module pipeline_pc_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic [31:0] i_wdata,
    output logic [31:0] rdata
);
    logic [31:0] r_pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= '0;
        end else if (i_en) begin
            r_pc <= i_wdata;
        end
    end

    assign rdata = r_pc;
endmodule

// ---------------------------------------------------------------------------
// Byte-wide instruction memory with a 5-byte little-endian read window.
// Contents are not touched by reset; the write port is a load path.
// ---------------------------------------------------------------------------
module pipeline_imem #(
    parameter int IMEM_BYTES = 512,
    parameter int AW         = 9
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [31:0]   i_addr,
    output logic [39:0]   o_rdata
);
    logic [7:0] mem [0:IMEM_BYTES-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    // Each byte of the window wraps independently at the end of memory.
    for (genvar k = 0; k < 5; k++) begin : g_rd
        logic [AW-1:0] w_idx;
        assign w_idx = AW'((i_addr + 32'(k)) % 32'(IMEM_BYTES));
        assign o_rdata[8*k +: 8] = mem[w_idx];
    end
endmodule

// ---------------------------------------------------------------------------
// Fetch: reads the instruction window and predecodes its length.
// ---------------------------------------------------------------------------
module pipeline_fetch #(
    parameter int IMEM_BYTES = 512,
    parameter int AW         = 9
) (
    input  logic          clk,
    input  logic [31:0]   i_pc,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    output logic [39:0]   o_instr,
    output logic [2:0]    o_len
);
    logic [7:0] w_op;
    logic [1:0] w_mod;

    pipeline_imem #(.IMEM_BYTES(IMEM_BYTES), .AW(AW)) imem (
        .clk     (clk),
        .i_we    (i_we),
        .i_waddr (i_waddr),
        .i_wdata (i_wdata),
        .i_addr  (i_pc),
        .o_rdata (o_instr)
    );

    assign w_op  = o_instr[7:0];
    assign w_mod = o_instr[15:14];

    always_comb begin
        o_len = 3'd1;
        if (w_op[7:3] == 5'b10111 || w_op == 8'h05 || w_op == 8'h2D) begin
            o_len = 3'd5;
        end else if ((w_op == 8'h89 || w_op == 8'h01) && w_mod == 2'b11) begin
            o_len = 3'd2;
        end
    end
endmodule

// ---------------------------------------------------------------------------
// Top level pipeline.
// ---------------------------------------------------------------------------
module pipeline_top #(
    parameter int IMEM_BYTES = 512
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] debug_pc,
    output logic [31:0] debug_result
);
    localparam int AW = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;

    localparam logic [1:0] c_OP_PASS = 2'd0;   // result = operand B
    localparam logic [1:0] c_OP_ADD  = 2'd1;
    localparam logic [1:0] c_OP_SUB  = 2'd2;

    localparam logic [1:0] c_B_IMM   = 2'd0;   // operand B source
    localparam logic [1:0] c_B_REG   = 2'd1;
    localparam logic [1:0] c_B_ONE   = 2'd2;

    // IF
    logic [31:0] F_pc_current;
    logic [39:0] F_instr;
    logic [2:0]  w_f_len;
    logic        r_halted;
    logic        w_stall;

    // ID
    logic        D_valid;
    logic [39:0] D_instr;
    logic [31:0] D_imm;
    logic [2:0]  w_d_src1, w_d_src2, w_d_dst;
    logic [1:0]  w_d_op, w_d_bsel;
    logic        w_d_we, w_d_use1, w_d_use2;

    // RR
    logic        RR_valid;
    logic [2:0]  RR_src1_idx, RR_src2_idx;
    logic [31:0] RR_rdata1, RR_rdata2;
    logic [31:0] RR_imm;
    logic [2:0]  r_rr_dst;
    logic [1:0]  r_rr_op, r_rr_bsel;
    logic        r_rr_we, r_rr_use1, r_rr_use2;
    logic [31:0] w_rf1, w_rf2, w_rr_opb;

    // EX
    logic        E_valid;
    logic [31:0] E_src1, E_src2, E_result;
    logic [2:0]  r_e_dst;
    logic [1:0]  r_e_op;
    logic        r_e_we;

    // WB
    logic        WB_valid;
    logic [2:0]  WB_dst_idx;
    logic [31:0] WB_result;
    logic        r_wb_we;

    logic [31:0] r_regs [8];

    // ---------------------------------------------------------------- IF
    pipeline_pc_reg PC_REG (
        .clk     (clk),
        .rst     (rst),
        .i_en    (!w_stall && !r_halted),
        .i_wdata (F_pc_current + 32'(w_f_len)),
        .rdata   (F_pc_current)
    );

    pipeline_fetch #(.IMEM_BYTES(IMEM_BYTES), .AW(AW)) FETCH (
        .clk     (clk),
        .i_pc    (F_pc_current),
        .i_we    (1'b0),
        .i_waddr ({AW{1'b0}}),
        .i_wdata (8'h00),
        .o_instr (F_instr),
        .o_len   (w_f_len)
    );

    // ---------------------------------------------------------------- ID
    // Anything not recognised (including mod!=11 forms) decodes as NOP.
    always_comb begin
        D_imm    = '0;
        w_d_src1 = 3'd0;
        w_d_src2 = 3'd0;
        w_d_dst  = 3'd0;
        w_d_op   = c_OP_PASS;
        w_d_bsel = c_B_IMM;
        w_d_we   = 1'b0;
        w_d_use1 = 1'b0;
        w_d_use2 = 1'b0;
        if (D_valid) begin
            if (D_instr[7:3] == 5'b10111) begin              // MOV r,imm32
                D_imm   = D_instr[39:8];
                w_d_dst = D_instr[2:0];
                w_d_we  = 1'b1;
            end else if (D_instr[7:0] == 8'h05 || D_instr[7:0] == 8'h2D) begin
                D_imm    = D_instr[39:8];                    // ADD/SUB EAX,imm32
                w_d_op   = (D_instr[7:0] == 8'h05) ? c_OP_ADD : c_OP_SUB;
                w_d_use1 = 1'b1;
                w_d_we   = 1'b1;
            end else if (D_instr[7:4] == 4'h4) begin         // INC/DEC r
                w_d_src1 = D_instr[2:0];
                w_d_dst  = D_instr[2:0];
                w_d_op   = D_instr[3] ? c_OP_SUB : c_OP_ADD;
                w_d_bsel = c_B_ONE;
                w_d_use1 = 1'b1;
                w_d_we   = 1'b1;
            end else if ((D_instr[7:0] == 8'h89 || D_instr[7:0] == 8'h01)
                         && D_instr[15:14] == 2'b11) begin   // MOV/ADD rm,reg
                w_d_src1 = D_instr[10:8];
                w_d_src2 = D_instr[13:11];
                w_d_dst  = D_instr[10:8];
                w_d_op   = (D_instr[7:0] == 8'h01) ? c_OP_ADD : c_OP_PASS;
                w_d_bsel = c_B_REG;
                w_d_use1 = (D_instr[7:0] == 8'h01);
                w_d_use2 = 1'b1;
                w_d_we   = 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- RR
    // Register file read with write-before-read from the WB stage.
    assign w_rf1 = (WB_valid && r_wb_we && WB_dst_idx == RR_src1_idx)
                   ? WB_result : r_regs[RR_src1_idx];
    assign w_rf2 = (WB_valid && r_wb_we && WB_dst_idx == RR_src2_idx)
                   ? WB_result : r_regs[RR_src2_idx];

`ifdef PIPELINE_FORWARD_EN
    // EX is the youngest producer, so it overrides the WB/regfile value.
    assign RR_rdata1 = (r_rr_use1 && E_valid && r_e_we && r_e_dst == RR_src1_idx)
                       ? E_result : w_rf1;
    assign RR_rdata2 = (r_rr_use2 && E_valid && r_e_we && r_e_dst == RR_src2_idx)
                       ? E_result : w_rf2;
    assign w_stall   = 1'b0;
`else
    assign RR_rdata1 = w_rf1;
    assign RR_rdata2 = w_rf2;
    // Hold RR until neither EX nor WB still owes a register it reads.
    assign w_stall = RR_valid && (
          (r_rr_use1 && ((E_valid && r_e_we && r_e_dst == RR_src1_idx) ||
                         (WB_valid && r_wb_we && WB_dst_idx == RR_src1_idx)))
       || (r_rr_use2 && ((E_valid && r_e_we && r_e_dst == RR_src2_idx) ||
                         (WB_valid && r_wb_we && WB_dst_idx == RR_src2_idx))));
`endif

    always_comb begin
        case (r_rr_bsel)
            c_B_IMM: w_rr_opb = RR_imm;
            c_B_REG: w_rr_opb = RR_rdata2;
            c_B_ONE: w_rr_opb = 32'd1;
            default: w_rr_opb = '0;
        endcase
    end

    // ---------------------------------------------------------------- EX
    always_comb begin
        case (r_e_op)
            c_OP_ADD: E_result = E_src1 + E_src2;
            c_OP_SUB: E_result = E_src1 - E_src2;
            default:  E_result = E_src2;
        endcase
    end

    // ------------------------------------------------------ stage registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_halted    <= 1'b0;
            D_valid     <= 1'b0;
            D_instr     <= '0;
            RR_valid    <= 1'b0;
            RR_src1_idx <= '0;
            RR_src2_idx <= '0;
            RR_imm      <= '0;
            r_rr_dst    <= '0;
            r_rr_op     <= c_OP_PASS;
            r_rr_bsel   <= c_B_IMM;
            r_rr_we     <= 1'b0;
            r_rr_use1   <= 1'b0;
            r_rr_use2   <= 1'b0;
            E_valid     <= 1'b0;
            E_src1      <= '0;
            E_src2      <= '0;
            r_e_dst     <= '0;
            r_e_op      <= c_OP_PASS;
            r_e_we      <= 1'b0;
            WB_valid    <= 1'b0;
            WB_dst_idx  <= '0;
            WB_result   <= '0;
            r_wb_we     <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (!w_stall) begin
                // Once halted, IF keeps feeding bubbles; HLT itself retires.
                D_valid <= !r_halted;
                D_instr <= F_instr;
                if (!r_halted && F_instr[7:0] == 8'hF4) begin
                    r_halted <= 1'b1;
                end
                RR_valid    <= D_valid;
                RR_src1_idx <= w_d_src1;
                RR_src2_idx <= w_d_src2;
                RR_imm      <= D_imm;
                r_rr_dst    <= w_d_dst;
                r_rr_op     <= w_d_op;
                r_rr_bsel   <= w_d_bsel;
                r_rr_we     <= w_d_we;
                r_rr_use1   <= w_d_use1;
                r_rr_use2   <= w_d_use2;
                E_valid     <= RR_valid;
                E_src1      <= RR_rdata1;
                E_src2      <= w_rr_opb;
                r_e_dst     <= r_rr_dst;
                r_e_op      <= r_rr_op;
                r_e_we      <= r_rr_we;
            end else begin
                E_valid <= 1'b0;
                r_e_we  <= 1'b0;
            end
            WB_valid   <= E_valid;
            WB_dst_idx <= r_e_dst;
            WB_result  <= E_result;
            r_wb_we    <= E_valid && r_e_we;
            if (WB_valid && r_wb_we) begin
                r_regs[WB_dst_idx] <= WB_result;
            end
        end
    end

    assign debug_pc     = F_pc_current;
    assign debug_result = WB_result;
endmodule
`default_nettype wire

// File: tb/tb_pipeline_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_top
// Description : Directed self-checking bench for pipeline_top. Programs are
//               poked into the instruction memory while reset is held; WB
//               results, PC sequence, stall spacing, HLT drain and
//               mid-flight reset are compared against hand-derived values.
//               Honours PIPELINE_FORWARD_EN for the expected WB spacing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_top;
    localparam int IMEM = 512;
`ifdef PIPELINE_FORWARD_EN
    localparam int GAP = 1;   // back-to-back dependents retire every cycle
`else
    localparam int GAP = 3;   // two stall cycles plus one bubble drain
`endif

    logic        clk;
    logic        rst;
    logic [31:0] debug_pc;
    logic [31:0] debug_result;
    int          checks   = 0;
    int          failures = 0;
    int          n;

    pipeline_top #(.IMEM_BYTES(IMEM)) dut (
        .clk          (clk),
        .rst          (rst),
        .debug_pc     (debug_pc),
        .debug_result (debug_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Advance until WB holds a valid instruction; n = edges taken (bounded).
    task automatic wait_wb(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!dut.WB_valid && cnt < 20);
    endtask

    task automatic put(input int a, input logic [39:0] v, input int nb);
        for (int k = 0; k < nb; k++) begin
            dut.FETCH.imem.mem[a + k] = v[8*k +: 8];
        end
    endtask

    task automatic enter_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < IMEM; i++) begin
            dut.FETCH.imem.mem[i] = 8'h90;
        end
    endtask

    task automatic leave_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;

        // ---- MOV EAX,DEADBEEF: reset state, PC sequence, latency
        enter_reset();
        put(0, 40'hDEADBEEF_B8, 5);
        #1;
        chk("rst_pc", debug_pc, 32'h0);
        chk("rst_result", debug_result, 32'h0);
        chk("rst_valids", 32'({dut.D_valid, dut.RR_valid, dut.E_valid, dut.WB_valid}), 32'h0);
        leave_reset();
        chk("pc_before_fetch", debug_pc, 32'h0);
        tick();
        chk("pc_after_mov", debug_pc, 32'h5);
        chk("d_valid_first", 32'(dut.D_valid), 32'h1);
        tick();
        chk("pc_after_nop", debug_pc, 32'h6);
        tick();
        chk("wb_not_yet", 32'(dut.WB_valid), 32'h0);
        tick();
        chk("mov_wb_valid", 32'(dut.WB_valid), 32'h1);
        chk("mov_wb_dst", 32'(dut.WB_dst_idx), 32'h0);
        chk("mov_result", debug_result, 32'hDEADBEEF);
        tick();
        chk("mov_eax_written", dut.r_regs[0], 32'hDEADBEEF);

        // ---- MOV EAX,1 ; ADD EAX,2 ; SUB EAX,1 back-to-back RAW chain
        enter_reset();
        put(0,  40'h00000001_B8, 5);
        put(5,  40'h00000002_05, 5);
        put(10, 40'h00000001_2D, 5);
        #1;
        chk("reset_clears_eax", dut.r_regs[0], 32'h0);
        leave_reset();
        wait_wb(n);
        chk("chain1_latency", 32'(n), 32'd4);
        chk("chain1_result", debug_result, 32'h1);
        wait_wb(n);
        chk("chain2_gap", 32'(n), 32'(GAP));
        chk("chain2_result", debug_result, 32'h3);
        wait_wb(n);
        chk("chain3_gap", 32'(n), 32'(GAP));
        chk("chain3_result", debug_result, 32'h2);
        chk("chain3_dst", 32'(dut.WB_dst_idx), 32'h0);
        tick();
        chk("chain_eax_final", dut.r_regs[0], 32'h2);

        // ---- MOV ECX,FFFFFFFF ; INC ECX ; MOV EDX,ECX (wrap-around)
        enter_reset();
        put(0, 40'hFFFFFFFF_B9, 5);
        put(5, 40'h00000000_41, 1);
        put(6, 40'h000000CA89, 2);
        leave_reset();
        wait_wb(n);
        chk("movecx_result", debug_result, 32'hFFFFFFFF);
        chk("movecx_dst", 32'(dut.WB_dst_idx), 32'h1);
        wait_wb(n);
        chk("inc_result", debug_result, 32'h0);
        chk("inc_dst", 32'(dut.WB_dst_idx), 32'h1);
        chk("ecx_before_inc", dut.r_regs[1], 32'hFFFFFFFF);
        wait_wb(n);
        chk("movedx_result", debug_result, 32'h0);
        chk("movedx_dst", 32'(dut.WB_dst_idx), 32'h2);
        tick();
        tick();
        chk("ecx_final", dut.r_regs[1], 32'h0);
        chk("edx_final", dut.r_regs[2], 32'h0);

        // ---- 0F (unsupported -> NOP) then HLT: drain and freeze
        enter_reset();
        put(0, 40'h00000000_0F, 1);
        put(1, 40'h00000000_F4, 1);
        leave_reset();
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 1) chk("pc_after_0f", debug_pc, 32'h1);
            if (i == 4) begin
                chk("op0f_retires", 32'(dut.WB_valid), 32'h1);
                chk("op0f_no_write", 32'(dut.r_wb_we), 32'h0);
            end
        end
        chk("hlt_pc_frozen", debug_pc, 32'h2);
        chk("hlt_wb_drained", 32'(dut.WB_valid), 32'h0);
        chk("hlt_d_bubble", 32'(dut.D_valid), 32'h0);
        chk("hlt_regs_clean", dut.r_regs[0] | dut.r_regs[1] | dut.r_regs[2] | dut.r_regs[3]
                              | dut.r_regs[4] | dut.r_regs[5] | dut.r_regs[6] | dut.r_regs[7], 32'h0);

        // ---- reset while MOV EAX is in EX, then restart from PC 0
        enter_reset();
        put(0, 40'h11111111_BB, 5);
        put(6, 40'hDEADBEEF_B8, 5);
        leave_reset();
        for (int i = 0; i < 5; i++) tick();
        chk("ebx_written", dut.r_regs[3], 32'h11111111);
        chk("mov_in_ex", 32'(dut.E_valid), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_valids", 32'({dut.D_valid, dut.RR_valid, dut.E_valid, dut.WB_valid}), 32'h0);
        chk("midrst_ebx", dut.r_regs[3], 32'h0);
        chk("midrst_pc", debug_pc, 32'h0);
        chk("midrst_result", debug_result, 32'h0);
        chk("midrst_imem_kept", 32'(dut.FETCH.imem.mem[0]), 32'hBB);
        leave_reset();
        tick();
        chk("restart_pc", debug_pc, 32'h5);
        chk("restart_opcode", 32'(dut.D_instr[7:0]), 32'hBB);
        wait_wb(n);
        chk("restart_latency", 32'(n), 32'd3);
        chk("restart_result", debug_result, 32'h11111111);
        chk("restart_dst", 32'(dut.WB_dst_idx), 32'h3);
        chk("restart_eax_clear", dut.r_regs[0], 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
